// File: rtl/norm_shift.sv
// Pipelined normalizing left shifter: Mant = Sum << NormCnt over $clog2(WIDTH) valid/ready stages.
// Define NORM_EXP_EN to add the exponent adjust path (Exp, ExpOut, Uflow).
module norm_shift #(
  parameter int unsigned WIDTH = 64,
  localparam int unsigned LW = $clog2(WIDTH)
`ifdef NORM_EXP_EN
  , parameter int unsigned EW = 11
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] Sum,
  input  logic [LW-1:0]    NormCnt,
  input  logic             NzIn,
`ifdef NORM_EXP_EN
  input  logic [EW-1:0]    Exp,
  output logic [EW-1:0]    ExpOut,
  output logic             Uflow,
`endif
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Mant,
  output logic             Zero
);

`ifdef NORM_EXP_EN
  // Exponent result is fully known at entry; it then rides along with the data.
  localparam int unsigned CW = (EW > LW) ? EW : LW;
  logic [CW-1:0] exp_w, cnt_w;
  logic          uf0;
  logic [EW-1:0] eo0;

  assign exp_w = CW'(Exp);
  assign cnt_w = CW'(NormCnt);
  assign uf0   = NzIn & (cnt_w > exp_w);
  assign eo0   = (NzIn & ~uf0) ? EW'(exp_w - cnt_w) : '0;
`endif

  for (genvar k = 0; k < LW; k++) begin : g_stg
    localparam int unsigned B  = LW - 1 - k;
    localparam int unsigned SH = 1 << B;

    logic             v_in, z_in, rdy, v_q, z_q;
    logic [WIDTH-1:0] d_in, d_q;
    logic [B:0]       c_in;
`ifdef NORM_EXP_EN
    logic [EW-1:0]    e_in, e_q;
    logic             u_in, u_q;
`endif

    if (k == 0) begin : g_src
      assign v_in = InValid;
      assign d_in = NzIn ? Sum : '0;
      assign c_in = NormCnt;
      assign z_in = ~NzIn;
`ifdef NORM_EXP_EN
      assign e_in = eo0;
      assign u_in = uf0;
`endif
    end else begin : g_src
      assign v_in = g_stg[k-1].v_q;
      assign d_in = g_stg[k-1].d_q;
      assign c_in = g_stg[k-1].g_cnt.c_q;
      assign z_in = g_stg[k-1].z_q;
`ifdef NORM_EXP_EN
      assign e_in = g_stg[k-1].e_q;
      assign u_in = g_stg[k-1].u_q;
`endif
    end

    // Combinational ready chain: a full stage still loads if its successor drains.
    if (k == LW - 1) begin : g_rdy
      assign rdy = ~v_q | OutReady;
    end else begin : g_rdy
      assign rdy = ~v_q | g_stg[k+1].rdy;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        d_q <= '0;
        z_q <= 1'b0;
`ifdef NORM_EXP_EN
        e_q <= '0;
        u_q <= 1'b0;
`endif
      end else if (rdy) begin
        v_q <= v_in;
        d_q <= c_in[B] ? (d_in << SH) : d_in;
        z_q <= z_in;
`ifdef NORM_EXP_EN
        e_q <= e_in;
        u_q <= u_in;
`endif
      end
    end

    // Only the count bits still needed by later stages are carried forward.
    if (B > 0) begin : g_cnt
      logic [B-1:0] c_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) c_q <= '0;
        else if (rdy) c_q <= c_in[B-1:0];
      end
    end
  end

  assign InReady  = g_stg[0].rdy;
  assign OutValid = g_stg[LW-1].v_q;
  assign Mant     = g_stg[LW-1].d_q;
  assign Zero     = g_stg[LW-1].z_q;
`ifdef NORM_EXP_EN
  assign ExpOut   = g_stg[LW-1].e_q;
  assign Uflow    = g_stg[LW-1].u_q;
`endif

endmodule
